// File: rtl/fetch_unit_if.sv
// Bundles the controller request/response, ROB redirect and decoder queue
// signals of the fetch stage. The fetch unit uses the master view and its
// surroundings (controller, ROB, decoder) use the slave view.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  if2ctrl_en;
  logic [ADDR_WIDTH-1:0] next_PC;
  logic                  inst_rdy;
  logic [INST_WIDTH-1:0] inst_out;
  logic                  rob_flush;
  logic [ADDR_WIDTH-1:0] flush_PC;
  logic                  dec_ready;
  logic                  iq_valid;
  logic [INST_WIDTH-1:0] iq_inst;
  logic [ADDR_WIDTH-1:0] iq_pc;
  logic                  iq_is_c;
  logic [ADDR_WIDTH-1:0] iq_pred_pc;

  modport master (
    output if2ctrl_en, next_PC, iq_valid, iq_inst, iq_pc, iq_is_c, iq_pred_pc,
    input  inst_rdy, inst_out, rob_flush, flush_PC, dec_ready
  );

  modport slave (
    input  if2ctrl_en, next_PC, iq_valid, iq_inst, iq_pc, iq_is_c, iq_pred_pc,
    output inst_rdy, inst_out, rob_flush, flush_PC, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one request at a time to the memory
// controller, pre-decodes compressed length and JAL targets, and buffers
// fetched words in a small FIFO for the decoder. A ROB flush redirects the
// PC and empties the queue; a request already in flight is completed and
// its word thrown away.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    IQ_DEPTH   = 8,
  parameter int                    IQ_PTR_W   = 3,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic           clk,
  input logic           rst_in,
  input logic           rdy_in,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  localparam logic [6:0]            OPC_JAL   = 7'b1101111;
  localparam logic [IQ_PTR_W:0]     DEPTH_CNT = (IQ_PTR_W+1)'(IQ_DEPTH);
  localparam logic [IQ_PTR_W:0]     CNT_ONE   = (IQ_PTR_W+1)'(1);
  localparam logic [IQ_PTR_W-1:0]   PTR_ONE   = IQ_PTR_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FOUR = ADDR_WIDTH'(4);

  state_t                state_q;
  logic                  fetchEn_q;
  logic [ADDR_WIDTH-1:0] nextPc_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [IQ_PTR_W:0]     count_q;
  logic [IQ_PTR_W-1:0]   head_q;
  logic [IQ_PTR_W-1:0]   tail_q;

  logic [INST_WIDTH-1:0] instMem [IQ_DEPTH];
  logic [ADDR_WIDTH-1:0] pcMem   [IQ_DEPTH];
  logic [ADDR_WIDTH-1:0] predMem [IQ_DEPTH];
  logic                  isCMem  [IQ_DEPTH];

  logic                  isC_d;
  logic [ADDR_WIDTH-1:0] jalOff_d;
  logic [ADDR_WIDTH-1:0] pred_d;
  logic                  pushEn;
  logic                  popEn;

  // A word is queued only when it answers a live (non-flushed) request; the
  // head leaves when the decoder takes it, unless a flush is wiping the queue.
  assign pushEn = rdy_in && (state_q == ST_WAIT) && bus.inst_rdy && !bus.rob_flush;
  assign popEn  = rdy_in && (count_q != '0) && bus.dec_ready && !bus.rob_flush;

  // Pre-decode of the returning word: length from the low two bits, and the
  // JAL immediate reassembled and sign-extended; everything else falls through.
  always_comb begin
    isC_d    = (bus.inst_out[1:0] != 2'b11);
    jalOff_d = {{(ADDR_WIDTH-21){bus.inst_out[31]}}, bus.inst_out[31], bus.inst_out[19:12],
                bus.inst_out[20], bus.inst_out[30:21], 1'b0};
    if (isC_d) begin
      pred_d = nextPc_q + ADDR_TWO;
    end else if (bus.inst_out[6:0] == OPC_JAL) begin
      pred_d = nextPc_q + jalOff_d;
    end else begin
      pred_d = nextPc_q + ADDR_FOUR;
    end
  end

  // Queue storage; occupancy and pointers live with the FSM so a flush can
  // clear them together with the redirect.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      instMem[tail_q] <= bus.inst_out;
      pcMem[tail_q]   <= nextPc_q;
      predMem[tail_q] <= pred_d;
      isCMem[tail_q]  <= isC_d;
    end
  end

  // Request FSM plus queue bookkeeping; rdy_in low freezes everything.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      fetchEn_q <= 1'b0;
      nextPc_q  <= RESET_PC;
      pc_q      <= RESET_PC;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else if (rdy_in) begin
      if (bus.rob_flush) begin
        count_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        pc_q    <= bus.flush_PC;
        unique case (state_q)
          ST_WAIT: begin
            if (bus.inst_rdy) begin
              fetchEn_q <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (bus.inst_rdy) begin
              fetchEn_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end else begin
        if (pushEn) tail_q <= tail_q + PTR_ONE;
        if (popEn) head_q <= head_q + PTR_ONE;
        unique case ({pushEn, popEn})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: ;
        endcase
        unique case (state_q)
          ST_IDLE: begin
            if (count_q < DEPTH_CNT) begin
              fetchEn_q <= 1'b1;
              nextPc_q  <= pc_q;
              state_q   <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (bus.inst_rdy) begin
              pc_q      <= pred_d;
              fetchEn_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
          ST_DRAIN: begin
            if (bus.inst_rdy) begin
              fetchEn_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
          default: begin
            fetchEn_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.if2ctrl_en = fetchEn_q;
  assign bus.next_PC    = nextPc_q;
  assign bus.iq_valid   = (count_q != '0);
  assign bus.iq_inst    = instMem[head_q];
  assign bus.iq_pc      = pcMem[head_q];
  assign bus.iq_is_c    = isCMem[head_q];
  assign bus.iq_pred_pc = predMem[head_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios for reset, pre-decode, queue
// full, flush and freeze, followed by a long randomized run checked against
// a queue-based model of the fetch/decode contract.
module tb_fetch_unit;

  logic clk;
  logic rst_in;
  logic rdy_in;
  int   total;
  int   bad;

  fetch_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

  fetch_unit dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
    logic        isC;
  } entry_t;

  entry_t modelQ[$];

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle: let the DUT see the current inputs, then return at the
  // falling edge where outputs are sampled and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rdy, input logic ir, input logic [31:0] w,
                               input logic dec, input logic fl, input logic [31:0] fpc);
    rdy_in        = rdy;
    bus.inst_rdy  = ir;
    bus.inst_out  = w;
    bus.dec_ready = dec;
    bus.rob_flush = fl;
    bus.flush_PC  = fpc;
  endtask

  // Spec-level next-PC rule computed arithmetically from the instruction fields.
  function automatic logic [31:0] modelPred(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] off;
    if (w[1:0] != 2'b11) return pc + 32'd2;
    if (w[6:0] == 7'h6F) begin
      off = 32'(w[30:21]) * 2 + 32'(w[20]) * 2048 + 32'(w[19:12]) * 4096;
      if (w[31]) off = off - 32'h0010_0000;
      return pc + off;
    end
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 3)
      0: r[1:0] = 2'($urandom_range(0, 2));
      1: r[6:0] = 7'h6F;
      default: begin
        r[1:0] = 2'b11;
        if (r[6:0] == 7'h6F) r[2] = 1'b0;
      end
    endcase
    return r;
  endfunction

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_in = 1'b1;
    tick();
    total++;
    if (bus.if2ctrl_en !== 1'b0 || bus.next_PC !== 32'h0 || bus.iq_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state got en=%0b pc=%h v=%0b exp en=0 pc=0 v=0",
               bus.if2ctrl_en, bus.next_PC, bus.iq_valid);
    end
    rst_in = 1'b0;
    tick();
    total++;
    if (bus.if2ctrl_en !== 1'b1 || bus.next_PC !== 32'h0) begin
      bad++;
      $display("[TB] FAIL first_request got en=%0b pc=%h exp en=1 pc=0", bus.if2ctrl_en, bus.next_PC);
    end
  endtask

  task automatic test_predecode();
    logic [31:0] addrT [5] = '{32'h0, 32'h4, 32'h6, 32'h8, 32'h18};
    logic [31:0] instT [5] = '{32'h00000013, 32'h00004501, 32'h00000001, 32'h0100006F, 32'hFF9FF06F};
    logic [31:0] predT [5] = '{32'h4, 32'h6, 32'h8, 32'h18, 32'h10};
    logic        cT    [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, instT[k], 1'b0, 1'b0, 32'h0);
      tick();
      total++;
      if (bus.iq_valid !== 1'b1 || bus.iq_inst !== instT[k] || bus.iq_pc !== addrT[k] ||
          bus.iq_pred_pc !== predT[k] || bus.iq_is_c !== cT[k] || bus.if2ctrl_en !== 1'b0) begin
        bad++;
        $display("[TB] FAIL predecode_%0d got v=%0b inst=%h pc=%h pred=%h c=%0b en=%0b exp inst=%h pc=%h pred=%h c=%0b en=0",
                 k, bus.iq_valid, bus.iq_inst, bus.iq_pc, bus.iq_pred_pc, bus.iq_is_c, bus.if2ctrl_en,
                 instT[k], addrT[k], predT[k], cT[k]);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      total++;
      if (bus.if2ctrl_en !== 1'b1 || bus.next_PC !== predT[k] || bus.iq_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL next_request_%0d got en=%0b pc=%h v=%0b exp en=1 pc=%h v=0",
                 k, bus.if2ctrl_en, bus.next_PC, bus.iq_valid, predT[k]);
      end
    end
  endtask

  task automatic test_queue_full();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.if2ctrl_en !== 1'b0 || bus.iq_pc !== 32'h10) begin
        bad++;
        $display("[TB] FAIL full_stall got en=%0b head=%h exp en=0 head=10", bus.if2ctrl_en, bus.iq_pc);
      end
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.if2ctrl_en !== 1'b0 || bus.iq_pc !== 32'h14) begin
      bad++;
      $display("[TB] FAIL full_pop got en=%0b head=%h exp en=0 head=14", bus.if2ctrl_en, bus.iq_pc);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.if2ctrl_en !== 1'b1 || bus.next_PC !== 32'h30) begin
      bad++;
      $display("[TB] FAIL full_resume got en=%0b pc=%h exp en=1 pc=30", bus.if2ctrl_en, bus.next_PC);
    end
  endtask

  task automatic test_flush_wait();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.iq_valid !== 1'b0 || bus.if2ctrl_en !== 1'b1 || bus.next_PC !== 32'h30) begin
        bad++;
        $display("[TB] FAIL drain_hold got v=%0b en=%0b pc=%h exp v=0 en=1 pc=30",
                 bus.iq_valid, bus.if2ctrl_en, bus.next_PC);
      end
      tick();
    end
    applyStimulus(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.iq_valid !== 1'b0 || bus.if2ctrl_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_discard got v=%0b en=%0b exp v=0 en=0", bus.iq_valid, bus.if2ctrl_en);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.if2ctrl_en !== 1'b1 || bus.next_PC !== 32'h100) begin
      bad++;
      $display("[TB] FAIL flush_target got en=%0b pc=%h exp en=1 pc=100", bus.if2ctrl_en, bus.next_PC);
    end
  endtask

  task automatic test_flush_coincident();
    applyStimulus(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b1, 32'h100);
    tick();
    total++;
    if (bus.iq_valid !== 1'b0 || bus.if2ctrl_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL coincident_drop got v=%0b en=%0b exp v=0 en=0", bus.iq_valid, bus.if2ctrl_en);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.if2ctrl_en !== 1'b1 || bus.next_PC !== 32'h100) begin
      bad++;
      $display("[TB] FAIL coincident_target got en=%0b pc=%h exp en=1 pc=100", bus.if2ctrl_en, bus.next_PC);
    end
  endtask

  task automatic test_freeze();
    applyStimulus(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, (k % 2) == 0, 32'h00004501, 1'b1, k == 2, 32'h300);
      tick();
      total++;
      if (bus.if2ctrl_en !== 1'b1 || bus.next_PC !== 32'h104 || bus.iq_valid !== 1'b1 ||
          bus.iq_pc !== 32'h100) begin
        bad++;
        $display("[TB] FAIL freeze_%0d got en=%0b pc=%h v=%0b head=%h exp en=1 pc=104 v=1 head=100",
                 k, bus.if2ctrl_en, bus.next_PC, bus.iq_valid, bus.iq_pc);
      end
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.if2ctrl_en !== 1'b1 || bus.next_PC !== 32'h104 || bus.iq_pc !== 32'h100) begin
      bad++;
      $display("[TB] FAIL thaw got en=%0b pc=%h head=%h exp en=1 pc=104 head=100",
               bus.if2ctrl_en, bus.next_PC, bus.iq_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] expPc;
    logic [31:0] reqAddr;
    logic        prevEn;
    logic        expEn;
    logic        draining;
    logic        rdy, ir, dec, fl;
    logic [31:0] w, fpc;
    entry_t      e;
    modelQ.delete();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_in = 1'b1;
    tick();
    rst_in   = 1'b0;
    expPc    = 32'h0;
    reqAddr  = 32'h0;
    prevEn   = 1'b0;
    expEn    = 1'b0;
    draining = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      total++;
      if (bus.if2ctrl_en !== expEn) begin
        bad++;
        $display("[TB] FAIL rand_en cyc=%0d got=%0b exp=%0b", c, bus.if2ctrl_en, expEn);
      end
      if (bus.if2ctrl_en && !prevEn) begin
        reqAddr = bus.next_PC;
        total++;
        if (bus.next_PC !== expPc) begin
          bad++;
          $display("[TB] FAIL rand_req_pc cyc=%0d got=%h exp=%h", c, bus.next_PC, expPc);
        end
      end else if (bus.if2ctrl_en && prevEn) begin
        total++;
        if (bus.next_PC !== reqAddr) begin
          bad++;
          $display("[TB] FAIL rand_pc_stable cyc=%0d got=%h exp=%h", c, bus.next_PC, reqAddr);
        end
      end
      total++;
      if (bus.iq_valid !== (modelQ.size() != 0)) begin
        bad++;
        $display("[TB] FAIL rand_valid cyc=%0d got=%0b exp=%0b", c, bus.iq_valid, modelQ.size() != 0);
      end else if (modelQ.size() != 0) begin
        e = modelQ[0];
        total++;
        if (bus.iq_inst !== e.inst || bus.iq_pc !== e.pc || bus.iq_pred_pc !== e.pred ||
            bus.iq_is_c !== e.isC) begin
          bad++;
          $display("[TB] FAIL rand_head cyc=%0d got inst=%h pc=%h pred=%h c=%0b exp inst=%h pc=%h pred=%h c=%0b",
                   c, bus.iq_inst, bus.iq_pc, bus.iq_pred_pc, bus.iq_is_c, e.inst, e.pc, e.pred, e.isC);
        end
      end
      rdy = ($urandom % 6) != 0;
      ir  = bus.if2ctrl_en && (($urandom % 3) == 0);
      w   = randInst();
      dec = ($urandom % 2) == 0;
      fl  = ($urandom % 30) == 0;
      fpc = $urandom & 32'hFFFF_FFFE;
      applyStimulus(rdy, ir, w, dec, fl, fpc);
      prevEn = bus.if2ctrl_en;
      if (!rdy) begin
        expEn = prevEn;
      end else begin
        if (prevEn) expEn = !ir;
        else expEn = (modelQ.size() < 8) && !fl;
        if (fl) begin
          modelQ.delete();
          expPc = fpc;
          if (prevEn) draining = !ir;
        end else begin
          if (modelQ.size() != 0 && dec) void'(modelQ.pop_front());
          if (prevEn && ir) begin
            if (draining) begin
              draining = 1'b0;
            end else begin
              e.inst = w;
              e.pc   = reqAddr;
              e.pred = modelPred(reqAddr, w);
              e.isC  = (w[1:0] != 2'b11);
              modelQ.push_back(e);
              expPc  = e.pred;
            end
          end
        end
      end
      tick();
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    total = 0;
    bad   = 0;
    rst_in = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    test_reset();
    test_predecode();
    test_queue_full();
    test_flush_wait();
    test_flush_coincident();
    test_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
